regfile_scanner: RTL

Read-side companion to `register_file`. On a start command, the scanner walks a contiguous, wrap-around range of register indices and drives the register file's read index. It captures each word and presents it on a valid/ready output stream, tagged with its index. It sits between the register file's read port and any consumer that needs a bulk dump, such as a debug or trace unit, or a context-save path.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scanner_out.sv | 42 ++++
 rtl/regfile_scanner.sv | 103 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file scanner.
package regfile_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} scan_state_t;

  localparam int NREGS_DEFAULT = 8;
  localparam int RSIZE_DEFAULT = 8;

  // Register index advance, wrapping at an arbitrary (non power-of-two) size.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned nregs);
    return (idx == nregs - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_scanner_out.sv
// Single-entry valid/ready holding register for one {tag, data} word.
module scan_out_reg #(
  parameter int IW    = 3,
  parameter int RSIZE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [IW-1:0]    i_tag,
  input  logic [RSIZE-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [IW-1:0]    o_tag,
  output logic [RSIZE-1:0] o_data,
  output logic             o_free
);

  logic             r_valid;
  logic [IW-1:0]    r_tag;
  logic [RSIZE-1:0] r_data;

  // Loading is only requested while free, so a load may overlap the outgoing transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_tag   = r_tag;
  assign o_data  = r_data;

endmodule

// File: rtl/regfile_scanner.sv
// Walks a wrap-around index range of a register file and streams each word
// out on a valid/ready port tagged with its index.
module regfile_scanner
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int RSIZE = RSIZE_DEFAULT,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IW-1:0]    first_i,
  input  logic [IW:0]      count_i,
  output logic [IW-1:0]    idx_o,
  input  logic [RSIZE-1:0] rdata_i,
  output logic [RSIZE-1:0] data_o,
  output logic [IW-1:0]    tag_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [IW:0] NREGS_W = (IW+1)'(NREGS);
  localparam logic [IW:0] REM_ONE = (IW+1)'(1);

  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW:0]   r_rem;
  logic          r_done;
  logic [IW:0]   w_count;
  logic          w_free;
  logic          w_load;
  logic          w_xfer;
  logic          w_last_xfer;

  // A zero count or one beyond the file size both mean a full pass.
  assign w_count = (count_i == '0 || count_i > NREGS_W) ? NREGS_W : count_i;
  assign w_xfer  = valid_o && ready_i;
  assign w_load  = (r_state == RUN) && w_free;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_xfer = 1'b0;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = RUN;
      RUN:     if (w_load && r_rem == REM_ONE) w_state_nxt = DRAIN;
      DRAIN: begin
        if (w_xfer) begin
          w_state_nxt = IDLE;
          w_last_xfer = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Index/remaining counters advance only on a capture, so stalls hold the scan point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx  <= '0;
      r_rem  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_xfer;
      if (r_state == IDLE && start_i) begin
        r_idx <= first_i;
        r_rem <= w_count;
      end else if (w_load) begin
        r_idx <= IW'(next_idx(32'(r_idx), NREGS));
        r_rem <= r_rem - REM_ONE;
      end
    end
  end

  scan_out_reg #(
    .IW    (IW),
    .RSIZE (RSIZE)
  ) u_out (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_load  (w_load),
    .i_tag   (r_idx),
    .i_data  (rdata_i),
    .i_ready (ready_i),
    .o_valid (valid_o),
    .o_tag   (tag_o),
    .o_data  (data_o),
    .o_free  (w_free)
  );

  assign idx_o  = r_idx;
  assign busy_o = (r_state != IDLE);
  assign done_o = r_done;

endmodule
